// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send, then shifts
// a byte out on device-generated clock edges and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 2500,
    parameter int TIMEOUT_CYC = 375000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       rdy,
    output logic       done,
    output logic       err,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe
);

    localparam int MAX_CYC = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        WAITREL
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [3:0]             n, n_nxt;
    logic [9:0]             frame_q, frame_nxt;
    logic                   rdy_nxt, done_nxt, err_nxt, c_oe_nxt, d_oe_nxt;
    logic [SYNC_STAGES-1:0] c_sync, d_sync;
    logic                   c_prev;
    logic                   c_s, d_s, fe, timeout;

    assign c_s     = c_sync[SYNC_STAGES-1];
    assign d_s     = d_sync[SYNC_STAGES-1];
    assign fe      = c_prev & ~c_s;
    assign timeout = (cnt == CW'(TIMEOUT_CYC - 1));

    // Idle PS/2 lines float high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_sync <= '1;
            d_sync <= '1;
            c_prev <= 1'b1;
        end else begin
            c_sync <= (c_sync << 1) | SYNC_STAGES'(ps2c_in);
            d_sync <= (d_sync << 1) | SYNC_STAGES'(ps2d_in);
            c_prev <= c_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            n       <= '0;
            frame_q <= '0;
            rdy     <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            n       <= n_nxt;
            frame_q <= frame_nxt;
            rdy     <= rdy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            ps2c_oe <= c_oe_nxt;
            ps2d_oe <= d_oe_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        n_nxt     = n;
        frame_nxt = frame_q;
        rdy_nxt   = rdy;
        done_nxt  = 1'b0;
        err_nxt   = err;
        c_oe_nxt  = ps2c_oe;
        d_oe_nxt  = ps2d_oe;

        case (state)
            IDLE: begin
                rdy_nxt  = 1'b1;
                c_oe_nxt = 1'b0;
                d_oe_nxt = 1'b0;
                if (start && rdy) begin
                    frame_nxt = {1'b1, ~^data, data};
                    err_nxt   = 1'b0;
                    rdy_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    c_oe_nxt  = 1'b1;
                    state_nxt = INHIBIT;
                end
            end

            INHIBIT: begin
                if (cnt == CW'(INHIBIT_CYC - 1)) begin
                    cnt_nxt   = '0;
                    n_nxt     = '0;
                    c_oe_nxt  = 1'b0;
                    d_oe_nxt  = 1'b1;
                    state_nxt = REQ;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            REQ, SEND, WAITREL: begin
                // The timeout check comes first so that it wins over a coincident clock edge.
                if (timeout) begin
                    cnt_nxt   = '0;
                    c_oe_nxt  = 1'b0;
                    d_oe_nxt  = 1'b0;
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    rdy_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    if (state == REQ) begin
                        state_nxt = SEND;
                    end else if (state == SEND) begin
                        if (fe) begin
                            n_nxt = n + 4'd1;
                            // Edges 1..10 put data, parity and the stop bit on the line; edge 11 is the ACK.
                            if (n == 4'd10) begin
                                err_nxt   = d_s;
                                state_nxt = WAITREL;
                            end else begin
                                d_oe_nxt  = ~frame_q[0];
                                frame_nxt = {1'b1, frame_q[9:1]};
                            end
                        end
                    end else if (c_s && d_s) begin
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                        rdy_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                c_oe_nxt  = 1'b0;
                d_oe_nxt  = 1'b0;
                rdy_nxt   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
